// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Baud-rate tick generator for the UART datapath. A cycle counter divides the
// clock by the active divisor to give the oversample tick. A sub-counter of
// oversample ticks then gives the mid-bit tick and the end-of-bit (baud) tick.
// A new divisor is held in a shadow register until a bit boundary, a resync,
// or an idle (disabled) edge, so that a bit period never changes mid-bit.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_en         count enable; counters hold while low
//   i_div_wr     strobe: write i_div into the shadow divisor
//   i_div        divisor, clock cycles per oversample tick (0/1 clamp to 2)
//   i_resync     strobe: restart the bit phase from zero
//   o_os_tick    one-cycle oversample tick
//   o_mid_tick   one-cycle mid-bit tick
//   o_baud_tick  one-cycle end-of-bit tick
//   o_div        divisor currently in effect
//   o_div_pend   a written divisor is waiting to take effect
module baud_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int OSR         = 16,
    parameter int DEFAULT_DIV = 78
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_div_wr,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_resync,
    output logic             o_os_tick,
    output logic             o_mid_tick,
    output logic             o_baud_tick,
    output logic [DIV_W-1:0] o_div,
    output logic             o_div_pend
);

    localparam int               SUB_W    = $clog2(OSR);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OSR / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OSR - 1);
    localparam logic [DIV_W-1:0] DIV_DEF  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);

    logic [DIV_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_shadow_q, div_shadow_d;
    logic             pend_q, pend_d;
    logic             os_tick_q, os_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic             baud_tick_q, baud_tick_d;

    logic [DIV_W-1:0] div_wr_val;
    logic             cyc_last;
    logic             baud_edge;
    logic             apply;

    always_comb begin
        div_wr_val   = (i_div < DIV_MIN) ? DIV_MIN : i_div;
        cyc_last     = (cyc_cnt_q == div_act_q - DIV_W'(1));
        baud_edge    = i_en && !i_resync && cyc_last && (sub_cnt_q == SUB_LAST);
        // The divisor may only change where the bit phase is not running.
        apply        = baud_edge || i_resync || !i_en;

        cyc_cnt_d    = cyc_cnt_q;
        sub_cnt_d    = sub_cnt_q;
        os_tick_d    = 1'b0;
        mid_tick_d   = 1'b0;
        baud_tick_d  = 1'b0;
        div_act_d    = div_act_q;
        div_shadow_d = div_shadow_q;
        pend_d       = pend_q;

        if (i_resync) begin
            cyc_cnt_d = '0;
            sub_cnt_d = '0;
        end else if (i_en) begin
            if (cyc_last) begin
                cyc_cnt_d   = '0;
                os_tick_d   = 1'b1;
                sub_cnt_d   = (sub_cnt_q == SUB_LAST) ? '0 : sub_cnt_q + SUB_W'(1);
                mid_tick_d  = (sub_cnt_q == SUB_MID);
                baud_tick_d = (sub_cnt_q == SUB_LAST);
            end else begin
                cyc_cnt_d = cyc_cnt_q + DIV_W'(1);
            end
        end

        if (apply) begin
            div_act_d = div_shadow_q;
            pend_d    = 1'b0;
        end

        // A write coinciding with an apply bypasses the shadow wait.
        if (i_div_wr) begin
            div_shadow_d = div_wr_val;
            if (apply) begin
                div_act_d = div_wr_val;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cyc_cnt_q    <= '0;
            sub_cnt_q    <= '0;
            div_act_q    <= DIV_DEF;
            div_shadow_q <= DIV_DEF;
            pend_q       <= 1'b0;
            os_tick_q    <= 1'b0;
            mid_tick_q   <= 1'b0;
            baud_tick_q  <= 1'b0;
        end else begin
            cyc_cnt_q    <= cyc_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            div_act_q    <= div_act_d;
            div_shadow_q <= div_shadow_d;
            pend_q       <= pend_d;
            os_tick_q    <= os_tick_d;
            mid_tick_q   <= mid_tick_d;
            baud_tick_q  <= baud_tick_d;
        end
    end

    assign o_os_tick   = os_tick_q;
    assign o_mid_tick  = mid_tick_q;
    assign o_baud_tick = baud_tick_q;
    assign o_div       = div_act_q;
    assign o_div_pend  = pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed scenarios plus a randomized phase, all
// checked every cycle against a model that tracks elapsed enabled edges
// within the current bit, and against absolute tick edge numbers.
module tb_baud_tick_gen;

    localparam int OSR = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        div_wr = 1'b0;
    logic [15:0] div = '0;
    logic        resync = 1'b0;
    logic        os_tick, mid_tick, baud_tick, div_pend;
    logic [15:0] div_out;

    baud_tick_gen #(.DIV_W(16), .OSR(OSR), .DEFAULT_DIV(78)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_wr(div_wr),
        .i_div(div), .i_resync(resync), .o_os_tick(os_tick),
        .o_mid_tick(mid_tick), .o_baud_tick(baud_tick), .o_div(div_out),
        .o_div_pend(div_pend)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state: m_e = enabled edges elapsed in the current bit
    int m_e, m_d, m_sh;
    bit m_pend, m_os, m_mid, m_baud;

    // edge bookkeeping since the last mark
    int t, first_os, first_mid, first_baud, last_baud, n_os, n_tick;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic mark();
        t = 0; first_os = 0; first_mid = 0; first_baud = 0; last_baud = 0;
        n_os = 0; n_tick = 0;
    endtask

    task automatic step(input bit s_en, input bit s_wr, input int s_div,
                        input bit s_rs, input bit s_rst);
        bit ap;
        int wv;
        rst_n = s_rst; en = s_en; div_wr = s_wr; div = 16'(s_div); resync = s_rs;
        @(posedge clk);
        if (!s_rst) begin
            m_e = 0; m_d = 78; m_sh = 78; m_pend = 0;
            m_os = 0; m_mid = 0; m_baud = 0;
        end else begin
            m_os = 0; m_mid = 0; m_baud = 0;
            if (s_rs) begin
                m_e = 0;
            end else if (s_en) begin
                m_e++;
                m_os   = (m_e % m_d == 0);
                m_mid  = (m_e == m_d * OSR / 2);
                m_baud = (m_e == m_d * OSR);
                if (m_baud) m_e = 0;
            end
            ap = m_baud || s_rs || !s_en;
            wv = (s_div < 2) ? 2 : s_div;
            if (ap) begin m_d = m_sh; m_pend = 0; end
            if (s_wr) begin
                m_sh = wv;
                if (ap) m_d = wv; else m_pend = 1;
            end
        end
        #1;
        t++;
        chk("os_tick", 32'(os_tick), 32'(m_os));
        chk("mid_tick", 32'(mid_tick), 32'(m_mid));
        chk("baud_tick", 32'(baud_tick), 32'(m_baud));
        chk("div", 32'(div_out), 32'(m_d));
        chk("div_pend", 32'(div_pend), 32'(m_pend));
        if (os_tick === 1'b1) begin n_os++; if (first_os == 0) first_os = t; end
        if (mid_tick === 1'b1 && first_mid == 0) first_mid = t;
        if (baud_tick === 1'b1) begin
            if (first_baud == 0) first_baud = t;
            last_baud = t;
        end
        if (os_tick === 1'b1 || mid_tick === 1'b1 || baud_tick === 1'b1) n_tick++;
    endtask

    initial begin
        mark();
        // reset state
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("rst_div", 32'(div_out), 32'd78);
        chk("rst_ticks", 32'({os_tick, mid_tick, baud_tick}), 32'd0);

        // default timing, then write 10 at edge 300
        mark();
        for (int i = 1; i <= 1408; i++) begin
            step(1, i == 300, 10, 0, 1);
            if (i == 1247) begin
                chk("pend_before_apply", 32'(div_pend), 32'd1);
                chk("div_before_apply", 32'(div_out), 32'd78);
            end
            if (i == 1248) chk("div_after_apply", 32'(div_out), 32'd10);
        end
        chk("first_os", 32'(first_os), 32'd78);
        chk("first_mid", 32'(first_mid), 32'd624);
        chk("first_baud", 32'(first_baud), 32'd1248);
        chk("second_baud", 32'(last_baud), 32'd1408);

        // resync at edge 500
        step(1, 0, 0, 0, 0);
        mark();
        for (int i = 1; i <= 499; i++) step(1, 0, 0, 0, 1);
        first_mid = 0; first_baud = 0; n_tick = 0;
        step(1, 0, 0, 1, 1);
        chk("resync_no_tick", 32'(n_tick), 32'd0);
        for (int i = 501; i <= 1748; i++) step(1, 0, 0, 0, 1);
        chk("resync_mid", 32'(first_mid), 32'd1124);
        chk("resync_baud", 32'(first_baud), 32'd1748);

        // enable gap of 50 cycles
        step(1, 0, 0, 0, 0);
        mark();
        for (int i = 1; i <= 200; i++) step(1, 0, 0, 0, 1);
        n_tick = 0;
        for (int i = 201; i <= 250; i++) step(0, 0, 0, 0, 1);
        chk("gap_no_ticks", 32'(n_tick), 32'd0);
        for (int i = 251; i <= 1298; i++) step(1, 0, 0, 0, 1);
        chk("gap_baud_delay", 32'(first_baud), 32'd1298);
        step(0, 1, 20, 0, 1);
        chk("gap_write_div", 32'(div_out), 32'd20);
        chk("gap_write_pend", 32'(div_pend), 32'd0);
        mark();
        for (int i = 1; i <= 320; i++) step(1, 0, 0, 0, 1);
        chk("gap_new_baud", 32'(first_baud), 32'd320);

        // clamp, overwrite, write with resync
        step(1, 1, 0, 0, 1);
        chk("clamp_pend", 32'(div_pend), 32'd1);
        step(1, 0, 0, 1, 1);
        chk("clamp_div", 32'(div_out), 32'd2);
        mark();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1);
        chk("clamp_os_rate", 32'(n_os), 32'd4);
        step(1, 1, 5, 0, 1);
        step(1, 1, 7, 0, 1);
        step(1, 0, 0, 1, 1);
        chk("overwrite_div", 32'(div_out), 32'd7);
        step(1, 1, 9, 1, 1);
        chk("wr_resync_div", 32'(div_out), 32'd9);
        chk("wr_resync_pend", 32'(div_pend), 32'd0);

        // reset mid-bit with a pending write
        for (int i = 0; i < 40; i++) step(1, i == 20, 30, 0, 1);
        chk("pre_rst_pend", 32'(div_pend), 32'd1);
        step(1, 0, 0, 0, 0);
        chk("mid_rst_div", 32'(div_out), 32'd78);
        chk("mid_rst_pend", 32'(div_pend), 32'd0);
        mark();
        for (int i = 1; i <= 1248; i++) step(1, 0, 0, 0, 1);
        chk("rerun_os", 32'(first_os), 32'd78);
        chk("rerun_mid", 32'(first_mid), 32'd624);
        chk("rerun_baud", 32'(first_baud), 32'd1248);

        // randomized: enable toggling, resyncs, divisor writes tied to resync
        step(1, 1, 3, 1, 1);
        for (int i = 0; i < 3000; i++) begin
            bit r_en, r_rs;
            r_en = ($urandom % 8) != 0;
            r_rs = ($urandom % 200) == 0;
            step(r_en, r_rs && ($urandom % 2 == 1), int'($urandom % 12), r_rs, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART datapath. Divides the system clock by a runtime-programmable divisor to produce an oversampling tick, and derives from it a once-per-bit baud tick and a mid-bit sample tick. The UART TX serialiser uses the baud tick; the RX deserialiser uses the oversample and mid-bit ticks and re-phases the generator on start-bit detection.

## Interface

Parameters:
- `DIV_W`, 16: width of the divisor and the cycle counter.
- `OSR`, 16: oversample ratio, in oversample ticks per bit. Must be even and ≥ 4.
- `DEFAULT_DIV`, 78: divisor loaded at reset. At 12 MHz with OSR 16 this gives about 9615 baud.

Ports:
- `i_clk`, input, 1: system clock. All logic is on the rising edge.
- `i_rst_n`, input, 1: reset. Synchronous and active-low.
- `i_en`, input, 1: count enable. When low, all counters hold.
- `i_div_wr`, input, 1: one-cycle strobe that writes `i_div` into the shadow divisor.
- `i_div`, input, `DIV_W`: new divisor value, in clock cycles per oversample tick.
- `i_resync`, input, 1: one-cycle strobe that restarts the bit phase from zero.
- `o_os_tick`, output, 1: one-cycle oversample tick.
- `o_mid_tick`, output, 1: one-cycle tick at the middle of each bit.
- `o_baud_tick`, output, 1: one-cycle tick at the end of each bit.
- `o_div`, output, `DIV_W`: divisor currently in effect.
- `o_div_pend`, output, 1: high while a written divisor is waiting to take effect.

## Operation

- State:
  - `cyc_cnt` (`DIV_W` bits, range 0..D−1), where D is the active divisor.
  - `sub_cnt` (`$clog2(OSR)` bits, range 0..OSR−1).
  - `div_act`, the active divisor.
  - `div_shadow` and `pend`, the pending write.
- Reset, evaluated at the clock edge while `i_rst_n` = 0:
  - `cyc_cnt`, `sub_cnt` and `pend` go to 0.
  - `div_act` and `div_shadow` go to `DEFAULT_DIV`.
  - All tick outputs go to 0.
  - Reset overrides every other input.
- Counting. On each edge with `i_en` = 1 and no resync:
  - If `cyc_cnt` = D−1:
    - `cyc_cnt` wraps to 0 and `o_os_tick` ← 1.
    - `sub_cnt` advances, wrapping from OSR−1 to 0.
    - If `sub_cnt` was OSR/2−1, then `o_mid_tick` ← 1.
    - If `sub_cnt` was OSR−1, then `o_baud_tick` ← 1.
  - Otherwise `cyc_cnt` increments and all ticks ← 0.
- All outputs are registered. Each tick is high for exactly one cycle.
- `o_mid_tick` and `o_baud_tick` are only ever high in the same cycle as `o_os_tick`.
- `i_en` = 0: counters hold their values and all ticks ← 0. Counting resumes from the held state.
- Divisor write (`i_div_wr` = 1):
  - Writes to `div_shadow` and sets `pend`.
  - Values 0 and 1 are clamped to 2.
  - A second write while `pend` is set overwrites `div_shadow`. The last write wins.
- Divisor apply. `div_act` ← `div_shadow` and `pend` ← 0 when any of the following occurs:
  - on the edge that produces a baud tick;
  - on a resync;
  - on any edge with `i_en` = 0.

  This means the bit period never changes mid-bit while the generator is running.
- Resync (`i_resync` = 1 and not in reset):
  - `cyc_cnt` ← 0, `sub_cnt` ← 0, all ticks ← 0.
  - Any pending divisor is applied.
  - Resync overrides the count and wrap logic, and is effective even when `i_en` = 0.
- Simultaneous `i_div_wr` and `i_resync`: the written value (after clamping) goes straight to `div_act`, and `pend` stays 0.
- Simultaneous `i_div_wr` and a baud-tick edge: the new value goes straight to `div_act` and takes effect for the next bit.
- Width rule: the compare `cyc_cnt` = D−1 is computed in `DIV_W` bits. D ≥ 2 is guaranteed by the clamp.

## Timing

- Number enabled edges 1, 2, … starting from the end of reset or a resync.
- With `i_en` held high:
  - `o_os_tick` is high after edge k·D.
  - `o_mid_tick` is high after edge D·(OSR/2 + m·OSR).
  - `o_baud_tick` is high after edge D·OSR·(m+1).
- Tick period: D cycles for the oversample tick and D·OSR cycles for the baud tick. There is no drift.
- `o_div` and `o_div_pend` update one cycle after the causing edge.
- Latency from `i_resync` to the first `o_mid_tick` is D·OSR/2 edges. The RX path samples the start bit centre from this.

## Test plan

- Reset, default parameters, `i_en` = 1:
  - `o_os_tick` is high after edges 78, 156, …;
  - the first `o_mid_tick` is after edge 624;
  - the first `o_baud_tick` is after edge 1248;
  - `o_div` = 78 and all ticks are 0 during reset.
- Write `i_div` = 10 at edge 300:
  - `o_div_pend` = 1 and `o_div` stays 78 until the baud tick at edge 1248;
  - the next `o_baud_tick` then comes at edge 1248 + 160 = 1408.
- Clamp and overwrite:
  - write `i_div` = 0 and check `o_div` reads 2 after a resync, with `o_os_tick` every 2 cycles;
  - write 5 then 7 without an apply in between, and check that 7 is the divisor applied.
- Pulse `i_resync` at edge 500 mid-bit:
  - no tick is produced on that edge;
  - `o_mid_tick` comes at edge 500 + 624;
  - `o_baud_tick` comes at edge 500 + 1248.
- Drop `i_en` for 50 cycles mid-count:
  - no ticks occur during the gap;
  - subsequent ticks are delayed by exactly 50 cycles;
  - a divisor written during the gap applies immediately.
- Assert `i_rst_n` = 0 for one cycle mid-bit with a pending write:
  - all ticks are 0 and `o_div_pend` = 0;
  - `o_div` = 78;
  - the tick sequence restarts exactly as in the first scenario.
